// File: rtl/adder_requester.sv
// adder_requester: synchronous initiator for a dynamic self-timed adder.
//   Latches one operand pair, pulses F to restart the adder timer, raises request, captures
//   sum/cout after add_rel is seen high on two consecutive edges, then holds the result.
//   A watchdog ends WAIT after MAX_WAIT cycles with out_timeout=1 and a zero result.
//   One transaction in flight; the result is held stable until out_ready.
// Ports:
//   i_clk, i_rst_n                          clock, async active-low reset
//   i_in_valid/o_in_ready, i_in_a/b/cin     upstream operand handshake
//   o_a, o_b, o_cin, o_f, o_request         drive to the adder
//   i_add_rel, i_add_sum, i_add_cout        adder release and result bus
//   o_out_valid/i_out_ready, o_out_sum/cout/timeout   downstream result handshake
module adder_requester #(
  parameter int WIDTH    = 32,
  parameter int F_CYCLES = 2,
  parameter int MAX_WAIT = 64
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_a,
  input  logic [WIDTH-1:0] i_in_b,
  input  logic             i_in_cin,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic             o_cin,
  output logic             o_f,
  output logic             o_request,
  input  logic             i_add_rel,
  input  logic [WIDTH-1:0] i_add_sum,
  input  logic             i_add_cout,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_sum,
  output logic             o_out_cout,
  output logic             o_out_timeout
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam int FW = (F_CYCLES > 1) ? $clog2(F_CYCLES + 1) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WAIT);
  localparam logic [FW-1:0] F_LAST   = FW'(F_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [FW-1:0] r_fcnt;
  logic          r_rel_q;
  logic          r_in_ready;

  logic w_accept;
  logic w_f_done;
  logic w_capture;
  logic w_timeout;
  logic w_release;

  assign w_accept  = (r_state == S_IDLE) && i_in_valid && r_in_ready;
  assign w_f_done  = (r_state == S_LAUNCH) && (r_fcnt == F_LAST);
  // Release must be seen on this edge and the previous one; a lone pulse only reloads the filter.
  assign w_capture = (r_state == S_WAIT) && i_add_rel && r_rel_q;
  // Fires on the edge where the counter would reach MAX_WAIT, so WAIT lasts MAX_WAIT cycles.
  assign w_timeout = (r_state == S_WAIT) && (r_cnt >= CNT_LAST);
  assign w_release = (r_state == S_HOLD) && i_out_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept)               w_state_nxt = S_LAUNCH;
      S_LAUNCH: if (w_f_done)               w_state_nxt = S_WAIT;
      S_WAIT:   if (w_capture || w_timeout) w_state_nxt = S_HOLD;
      S_HOLD:   if (w_release)              w_state_nxt = S_IDLE;
      default:                              w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      // Registered so that in_ready stays low through reset and rises on the first clock after.
      r_in_ready <= (w_state_nxt == S_IDLE);
    end
  end

  // Operand registers: loaded only on accept, so A/B/Cin are stable through LAUNCH and WAIT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_a   <= '0;
      o_b   <= '0;
      o_cin <= 1'b0;
    end else if (w_accept) begin
      o_a   <= i_in_a;
      o_b   <= i_in_b;
      o_cin <= i_in_cin;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_fcnt  <= '0;
      r_rel_q <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt  <= '0;
        r_fcnt <= '0;
      end else begin
        if (r_state == S_LAUNCH) r_fcnt <= r_fcnt + 1'b1;
        if ((r_state == S_WAIT) && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + 1'b1;
      end
      // Filter is only armed while WAITing so a stale release never leaks into the next launch.
      r_rel_q <= (r_state == S_WAIT) && i_add_rel;
    end
  end

  // Result registers: the adder bus is only sampled on a qualified capture, never when floating.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_out_sum     <= '0;
      o_out_cout    <= 1'b0;
      o_out_timeout <= 1'b0;
    end else if (w_capture) begin
      o_out_sum     <= i_add_sum;
      o_out_cout    <= i_add_cout;
      o_out_timeout <= 1'b0;
    end else if (w_timeout) begin
      o_out_sum     <= '0;
      o_out_cout    <= 1'b0;
      o_out_timeout <= 1'b1;
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_f         = (r_state == S_LAUNCH);
  assign o_request   = (r_state == S_WAIT);
  assign o_out_valid = (r_state == S_HOLD);

endmodule
